// File: rtl/outbuf_pkg.sv
// Shared types and codes for the output-buffer controller.
// Phase codes, FSM states and drain destination encodings.
package outbuf_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_FP   = 3'd1;
  localparam logic [2:0] PH_BP   = 3'd2;
  localparam logic [2:0] PH_WG   = 3'd3;

  localparam logic DST_INPREF = 1'b0;
  localparam logic DST_WPREF  = 1'b1;

  // Undefined phase codes behave like IDLE.
  function automatic logic phase_active(input logic [2:0] ph);
    return (ph == PH_FP) || (ph == PH_BP) || (ph == PH_WG);
  endfunction

endpackage

// File: rtl/outbuf_mem.sv
// Buffer storage: register array with one synchronous write port and one
// asynchronous read port. The array itself is not reset.
module outbuf_mem
  import outbuf_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/outbuf_ctrl.sv
// Output-buffer controller: captures SA/BN result vectors into a circular
// buffer and drains them, in FIFO order, to one of the two prefetchers.
module outbuf_ctrl
  import outbuf_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      fsm_rst_n,
  input  logic [2:0]                phase,
  input  logic                      out_en,
  input  logic [LANES*DATA_W-1:0]   sa_data,
  input  logic                      bn_valid,
  input  logic [LANES*DATA_W-1:0]   bn_data,
  input  logic                      buf_input_select,
  input  logic                      buf_output_select,
  input  logic                      drain_start,
  input  logic                      inpref_ready,
  input  logic                      wpref_ready,
  output logic                      inpref_valid,
  output logic                      wpref_valid,
  output logic [LANES*DATA_W-1:0]   drain_data,
  output logic [ADDR_W:0]           buf_count,
  output logic                      buf_full,
  output logic                      buf_empty,
  output logic                      drain_done,
  output logic                      ovf_err
);

  localparam int unsigned VEC_W = LANES * DATA_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [VEC_W-1:0]  out_data_q, out_data_d;
  logic              dst_sel_q, dst_sel_d;
  logic              ovf_q, ovf_d;

  logic              active;
  logic              wr_valid;
  logic [VEC_W-1:0]  wr_data;
  logic              wr_window;
  logic              wr_acc;
  logic              rd_acc;
  logic              dst_ready;
  logic              full;
  logic              start;
  logic              load;
  logic [ADDR_W:0]   mem_pending;
  logic [VEC_W-1:0]  mem_rdata;

  assign active    = phase_active(phase);
  assign wr_valid  = buf_input_select ? bn_valid : out_en;
  assign wr_data   = buf_input_select ? bn_data : sa_data;
  assign dst_ready = (dst_sel_q == DST_WPREF) ? wpref_ready : inpref_ready;
  assign rd_acc    = out_valid_q && dst_ready;
  assign full      = (count_q == CNT_FULL);
  assign wr_window = (state_q == S_FILL) || (state_q == S_DRAIN);
  // A full buffer still takes a write when the head beat leaves this cycle;
  // the slot it lands in was already moved into the output register.
  assign wr_acc    = wr_window && wr_valid && (!full || rd_acc);
  assign start     = (state_q == S_FILL) && drain_start;

  // count_q includes the beat parked in the output register.
  assign mem_pending = count_q - (ADDR_W + 1)'(out_valid_q);
  assign load = (start || (state_q == S_DRAIN)) && (!out_valid_q || rd_acc)
                && (mem_pending != '0);

  outbuf_mem #(
    .WIDTH  (VEC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && active),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dst_sel_d   = dst_sel_q;
    ovf_d       = ovf_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (wr_window && wr_valid && !wr_acc) begin
      ovf_d = 1'b1;
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_data_d  = mem_rdata;
      out_valid_d = 1'b1;
    end else if (rd_acc) begin
      out_valid_d = 1'b0;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (start) begin
      dst_sel_d = buf_output_select;
    end

    unique case (state_q)
      S_IDLE:  state_d = S_FILL;
      S_FILL:  if (drain_start) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase

    // IDLE phase wins over everything and silently aborts any drain.
    if (!active) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      dst_sel_q   <= DST_INPREF;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      dst_sel_q   <= dst_sel_d;
      ovf_q       <= ovf_d;
    end
  end

  assign inpref_valid = out_valid_q && (dst_sel_q == DST_INPREF);
  assign wpref_valid  = out_valid_q && (dst_sel_q == DST_WPREF);
  assign drain_data   = out_data_q;
  assign buf_count    = count_q;
  assign buf_full     = full;
  assign buf_empty    = (count_q == '0);
  assign drain_done   = (state_q == S_DONE);
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_outbuf_ctrl.sv
// Directed bench for outbuf_ctrl: fill/drain, backpressure, overflow,
// simultaneous read/write, abort, empty drain and asynchronous reset.
module tb_outbuf_ctrl;

  logic         clk;
  logic         fsm_rst_n;
  logic [2:0]   phase;
  logic         out_en;
  logic [127:0] sa_data;
  logic         bn_valid;
  logic [127:0] bn_data;
  logic         buf_input_select;
  logic         buf_output_select;
  logic         drain_start;
  logic         inpref_ready;
  logic         wpref_ready;
  logic         inpref_valid;
  logic         wpref_valid;
  logic [127:0] drain_data;
  logic [4:0]   buf_count;
  logic         buf_full;
  logic         buf_empty;
  logic         drain_done;
  logic         ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  outbuf_ctrl dut (
    .clk               (clk),
    .fsm_rst_n         (fsm_rst_n),
    .phase             (phase),
    .out_en            (out_en),
    .sa_data           (sa_data),
    .bn_valid          (bn_valid),
    .bn_data           (bn_data),
    .buf_input_select  (buf_input_select),
    .buf_output_select (buf_output_select),
    .drain_start       (drain_start),
    .inpref_ready      (inpref_ready),
    .wpref_ready       (wpref_ready),
    .inpref_valid      (inpref_valid),
    .wpref_valid       (wpref_valid),
    .drain_data        (drain_data),
    .buf_count         (buf_count),
    .buf_full          (buf_full),
    .buf_empty         (buf_empty),
    .drain_done        (drain_done),
    .ovf_err           (ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] mk(input int n);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(n * 8 + i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sa(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      out_en  = 1'b1;
      sa_data = mk(base + i);
      step();
    end
    out_en = 1'b0;
  endtask

  int rdy_pat [6] = '{0, 1, 0, 0, 1, 1};
  int exp_bp  [6] = '{11, 11, 12, 12, 12, 13};

  initial begin
    fsm_rst_n = 1'b0; phase = 3'd1; out_en = 1'b0; sa_data = '0; bn_valid = 1'b0;
    bn_data = '0; buf_input_select = 1'b0; buf_output_select = 1'b0; drain_start = 1'b0;
    inpref_ready = 1'b0; wpref_ready = 1'b0;
    #1;
    check("rst_inpref_valid", inpref_valid, 0);
    check("rst_wpref_valid", wpref_valid, 0);
    check("rst_buf_empty", buf_empty, 1);
    check("rst_buf_count", buf_count, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_drain_data", drain_data, 0);
    step(); step();

    // Release with a write pending: swallowed in S_IDLE.
    fsm_rst_n = 1'b1; out_en = 1'b1; sa_data = mk(77);
    step();
    out_en = 1'b0;
    check("idle_write_ignored", buf_count, 0);
    check("idle_write_no_ovf", ovf_err, 0);

    // Fill 5 and drain to the input prefetcher.
    push_sa(1, 5);
    check("fill5_count", buf_count, 5);
    check("fill5_not_empty", buf_empty, 0);
    buf_output_select = 1'b0; inpref_ready = 1'b1; drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("t2_inpref_valid", inpref_valid, 1);
      check("t2_wpref_valid", wpref_valid, 0);
      check("t2_data", drain_data, mk(k));
      check("t2_no_done", drain_done, 0);
      step();
    end
    check("t2_done", drain_done, 1);
    check("t2_valid_off", inpref_valid, 0);
    check("t2_empty", buf_empty, 1);
    step();
    check("t2_done_once", drain_done, 0);

    // Backpressure toward the weight prefetcher; the other ready is high to
    // make sure only the latched destination's ready counts.
    push_sa(11, 3);
    buf_output_select = 1'b1; wpref_ready = 1'b0; inpref_ready = 1'b1; drain_start = 1'b1;
    step();
    drain_start = 1'b0; buf_output_select = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wpref_ready = (rdy_pat[i] != 0);
      check("t3_wpref_valid", wpref_valid, 1);
      check("t3_inpref_valid", inpref_valid, 0);
      check("t3_data", drain_data, mk(exp_bp[i]));
      step();
    end
    check("t3_done", drain_done, 1);
    check("t3_valid_off", wpref_valid, 0);
    wpref_ready = 1'b0;
    step();

    // Overflow from the BN source; SA carries junk to expose a wrong mux.
    buf_input_select = 1'b1; bn_valid = 1'b1; out_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bn_data = mk(100 + k);
      sa_data = mk(900 + k);
      step();
    end
    bn_valid = 1'b0; out_en = 1'b0; buf_input_select = 1'b0;
    check("t4_full", buf_full, 1);
    check("t4_count", buf_count, 16);
    check("t4_ovf", ovf_err, 1);
    buf_output_select = 1'b0; inpref_ready = 1'b1; drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("t4_data", drain_data, mk(100 + k));
      step();
    end
    check("t4_done", drain_done, 1);
    check("t4_ovf_sticky", ovf_err, 1);

    // IDLE clears the sticky error.
    phase = 3'd0;
    step();
    check("idle_clears_ovf", ovf_err, 0);
    check("idle_count", buf_count, 0);
    phase = 3'd2;
    step();

    // Full buffer in S_DRAIN with concurrent writes; phase BP->WG mid-fill.
    push_sa(200, 8);
    phase = 3'd3;
    step();
    check("phase_change_retains", buf_count, 8);
    push_sa(208, 8);
    check("t5_full", buf_full, 1);
    inpref_ready = 1'b1; drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      out_en = 1'b1; sa_data = mk(300 + j);
      check("t5_count16", buf_count, 16);
      check("t5_data", drain_data, mk(200 + j));
      step();
    end
    out_en = 1'b0;
    for (int j = 4; j < 20; j++) begin
      check("t5_data", drain_data, (j < 16) ? mk(200 + j) : mk(300 + j - 16));
      step();
    end
    check("t5_done", drain_done, 1);
    check("t5_no_ovf", ovf_err, 0);
    step();

    // Abort a drain by going IDLE.
    push_sa(40, 3);
    inpref_ready = 1'b0; drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    check("t6_valid", inpref_valid, 1);
    phase = 3'd0;
    step();
    check("t6_abort_valid", inpref_valid, 0);
    check("t6_abort_count", buf_count, 0);
    check("t6_abort_no_done", drain_done, 0);
    phase = 3'd1;
    step();
    check("t6_abort_no_done_late", drain_done, 0);

    // Empty drain: done two cycles after the request, no beat.
    drain_start = 1'b1; inpref_ready = 1'b1;
    step();
    drain_start = 1'b0;
    check("t6_empty_no_valid", inpref_valid, 0);
    check("t6_empty_no_done_yet", drain_done, 0);
    step();
    check("t6_empty_done", drain_done, 1);
    check("t6_empty_no_valid2", inpref_valid | wpref_valid, 0);
    step();

    // Asynchronous reset in the middle of a drain.
    push_sa(50, 3);
    inpref_ready = 1'b0; drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    check("t1_valid_before", inpref_valid, 1);
    fsm_rst_n = 1'b0;
    #1;
    check("t1_async_valid", inpref_valid | wpref_valid, 0);
    check("t1_async_empty", buf_empty, 1);
    check("t1_async_done", drain_done, 0);
    step();
    check("t1_hold_valid", inpref_valid | wpref_valid, 0);
    fsm_rst_n = 1'b1;
    step();
    check("t1_post_valid", inpref_valid | wpref_valid, 0);
    check("t1_post_empty", buf_empty, 1);
    check("t1_post_done", drain_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
